// File: rtl/nios_system_speed_ramp_pio.sv
// Multi-channel speed-setpoint PIO: each channel slews its output toward a software target
// by STEP once per prescaler tick; supports bypass, global stop and a reached-target interrupt.
module nios_system_speed_ramp_pio #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 7,
  parameter int RESET_VAL = 15,
  parameter int MAX_VAL   = 100,
  parameter int PRESCALE  = 50000,
  parameter int AW        = $clog2(CHANNELS) + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic [CHANNELS-1:0]       at_target,
  output logic                      irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RST_V      = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_RST   = WIDTH'(1);

  typedef logic [WIDTH-1:0] val_t;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic [AW-1:0] ch_sel;
  logic [CW-1:0] ch_idx;
  logic [1:0]    reg_sel;
  logic          ch_ok;
  logic          wr;
  logic          stop;
  val_t          wr_tgt;

  logic [CHANNELS-1:0][WIDTH-1:0] tgt_v;
  logic [CHANNELS-1:0][WIDTH-1:0] cur_v;
  logic [CHANNELS-1:0][WIDTH-1:0] step_v;
  logic [CHANNELS-1:0][4:0]       ctrl_v;
  logic [CHANNELS-1:0]            irq_v;

  assign ch_sel  = address >> 2;
  assign ch_idx  = ch_sel[CW-1:0];
  assign reg_sel = address[1:0];
  assign ch_ok   = int'(ch_sel) < CHANNELS;
  assign wr      = chipselect & ~write_n & ch_ok;
  assign stop    = wr & (reg_sel == 2'd3) & writedata[2];
  assign wr_tgt  = (writedata > 32'(MAX_VAL)) ? MAX_V : writedata[WIDTH-1:0];

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    val_t             tgt_q, tgt_d, cur_q, cur_d, cur_nxt, step_q, step_d;
    logic             en_q, en_d, ie_q, ie_d, done_q, done_d;
    logic             sel;
    logic [WIDTH:0]   up_sum, dn_lim;

    assign sel    = wr & (ch_sel == AW'(c));
    assign up_sum = {1'b0, cur_q} + {1'b0, step_q};
    assign dn_lim = {1'b0, tgt_q} + {1'b0, step_q};

    // Ramp uses the pre-edge target; the extra bit keeps the sums from wrapping.
    always_comb begin
      cur_nxt = cur_q;
      if (!en_q) begin
        cur_nxt = tgt_q;
      end else if (tick) begin
        if (cur_q < tgt_q)
          cur_nxt = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[WIDTH-1:0];
        else if (cur_q > tgt_q)
          cur_nxt = ({1'b0, cur_q} <= dn_lim) ? tgt_q : cur_q - step_q;
      end
    end

    always_comb begin
      tgt_d  = tgt_q;
      step_d = step_q;
      en_d   = en_q;
      ie_d   = ie_q;
      done_d = done_q;
      cur_d  = cur_nxt;
      if (sel) begin
        case (reg_sel)
          2'd0: tgt_d = wr_tgt;
          2'd2: step_d = writedata[WIDTH-1:0];
          2'd3: begin
            en_d = writedata[0];
            ie_d = writedata[3];
            if (writedata[4]) done_d = 1'b0;
          end
          default: ;
        endcase
      end
      if (stop) begin
        tgt_d = '0;
        cur_d = '0;
      end else if ((cur_nxt != cur_q) && (cur_nxt == tgt_d)) begin
        done_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tgt_q  <= RST_V;
        cur_q  <= RST_V;
        step_q <= STEP_RST;
        en_q   <= 1'b1;
        ie_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        tgt_q  <= tgt_d;
        cur_q  <= cur_d;
        step_q <= step_d;
        en_q   <= en_d;
        ie_q   <= ie_d;
        done_q <= done_d;
      end
    end

    assign out_port[c*WIDTH +: WIDTH] = cur_q;
    assign at_target[c] = (cur_q == tgt_q);
    assign tgt_v[c]     = tgt_q;
    assign cur_v[c]     = cur_q;
    assign step_v[c]    = step_q;
    assign ctrl_v[c]    = {done_q, ie_q, 1'b0, cur_q == tgt_q, en_q};
    assign irq_v[c]     = done_q & ie_q;
  end

  assign irq = |irq_v;

  always_comb begin
    readdata = '0;
    if (ch_ok) begin
      case (reg_sel)
        2'd0:    readdata[WIDTH-1:0] = tgt_v[ch_idx];
        2'd1:    readdata[WIDTH-1:0] = cur_v[ch_idx];
        2'd2:    readdata[WIDTH-1:0] = step_v[ch_idx];
        default: readdata[4:0]       = ctrl_v[ch_idx];
      endcase
    end
  end

endmodule
